seg7_scan_display: RTL and testbench

Downstream consumer of the decade counter. It latches up to NUM_DIGITS BCD digits, which are the 4-bit counter outputs concatenated, and drives a common-anode multiplexed seven-segment display on the FPGA board. It time-multiplexes the digits with an internal refresh prescaler, decodes BCD to segments, and blanks leading zeros. All outputs are registered and active-low, to match the board.

---
 rtl/seg7_scan_display_if.sv | 25 ++
 rtl/seg7_scan_display.sv | 130 +++++++++++++
 tb/tb_seg7_scan_display.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_display_if.sv
// Bus bundle between the digit source and the multiplexed seven-segment scanner.
interface seg7_scan_display_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                      load;
    logic [4*NUM_DIGITS-1:0]   digits;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic                      blank;
    logic [6:0]                seg;
    logic                      dp;
    logic [NUM_DIGITS-1:0]     an;
    logic [IDX_W-1:0]          digit_idx;

    modport master (
        output load, digits, dp_in, blank,
        input  seg, dp, an, digit_idx
    );

    modport slave (
        input  load, digits, dp_in, blank,
        output seg, dp, an, digit_idx
    );
endinterface

// File: rtl/seg7_scan_display.sv
// Time-multiplexed common-anode seven-segment driver with BCD decode and
// leading-zero suppression. All outputs are registered and active-low.
module seg7_scan_display #(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned REFRESH_DIV   = 100000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    seg7_scan_display_if.slave bus
);
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned DIG_W = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic [IDX_W-1:0]      idx_q,    idx_d;
    logic [DIG_W-1:0]      shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0] sdp_q,    sdp_d;
    logic [6:0]            seg_q,    seg_d;
    logic                  dp_q,     dp_d;
    logic [NUM_DIGITS-1:0] an_q,     an_d;

    logic [NUM_DIGITS:0]   zero_from;
    logic [3:0]            cur_dig;
    logic                  cur_dp;
    logic                  cur_lz;

    // BCD to active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // Prescaler, scan index and shadow capture.
    always_comb begin
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        sdp_d    = sdp_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (bus.load) begin
            shadow_d = bus.digits;
            sdp_d    = bus.dp_in;
        end
    end

    // zero_from[i]: digit i and every higher digit are zero with no dp requested.
    always_comb begin
        zero_from             = '0;
        zero_from[NUM_DIGITS] = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] & (shadow_q[4*i +: 4] == 4'd0) & ~sdp_q[i];
        end
    end

    // Pick the digit, dp request and blanking flag of the slot being scanned.
    always_comb begin
        cur_dig = '0;
        cur_dp  = 1'b0;
        cur_lz  = 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_dig = shadow_q[4*i +: 4];
                cur_dp  = sdp_q[i];
                cur_lz  = (i != 0) && zero_from[i];
            end
        end
    end

    // Next output word; dark whenever blanked globally or as a leading zero.
    always_comb begin
        seg_d = 7'b1111111;
        dp_d  = 1'b1;
        an_d  = '1;
        if (!bus.blank && !(BLANK_LEADING && cur_lz)) begin
            an_d  = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = bcd_to_seg(cur_dig);
            dp_d  = ~cur_dp;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            sdp_q    <= '0;
            seg_q    <= 7'b1111111;
            dp_q     <= 1'b1;
            an_q     <= '1;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            sdp_q    <= sdp_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            an_q     <= an_d;
        end
    end

    assign bus.seg       = seg_q;
    assign bus.dp        = dp_q;
    assign bus.an        = an_q;
    assign bus.digit_idx = idx_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display: a 4-digit scanner and a 1-digit scanner fed by
// a decade counter, both checked cycle by cycle against a reference model.
module tb_seg7_scan_display;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        int         idx;
    } exp_t;

    localparam logic [6:0] SEG_TBL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    exp_t q1[$];
    exp_t q2[$];

    logic [31:0] m1_sh;
    logic [7:0]  m1_dp;
    int          m1_cnt;
    int          m1_idx;
    logic [31:0] m2_sh;

    seg7_scan_display_if #(.NUM_DIGITS(4)) bus1();
    seg7_scan_display_if #(.NUM_DIGITS(1)) bus2();

    seg7_scan_display #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_LEADING(1'b1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    seg7_scan_display #(.NUM_DIGITS(1), .REFRESH_DIV(1), .BLANK_LEADING(1'b1)) u_cnt_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Expected display word for a slot, derived from the numeric value of the shadow.
    function automatic exp_t model_out(input logic [31:0] sh, input logic [7:0] dpv,
                                       input int idx, input logic blk);
        exp_t e;
        int   v;
        logic lead;
        v    = int'((sh >> (4 * idx)) & 32'hF);
        lead = (idx > 0) && ((sh >> (4 * idx)) == 32'd0) && ((dpv >> idx) == 8'd0);
        e.idx = 0;
        if (blk || lead) begin
            e.an  = 8'hFF;
            e.seg = 7'h7F;
            e.dp  = 1'b1;
        end else begin
            e.an  = ~(8'd1 << idx);
            e.seg = SEG_TBL[v];
            e.dp  = ~dpv[idx];
        end
        return e;
    endfunction

    // Reference model of the 4-digit scanner, pushing one expectation per edge.
    initial begin
        exp_t e;
        m1_sh = '0; m1_dp = '0; m1_cnt = 0; m1_idx = 0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1;
                m1_sh = '0; m1_dp = '0; m1_cnt = 0; m1_idx = 0;
            end else begin
                e = model_out(m1_sh, m1_dp, m1_idx, bus1.blank);
                if (m1_cnt == 3) begin
                    m1_cnt = 0;
                    m1_idx = (m1_idx + 1) % 4;
                end else begin
                    m1_cnt++;
                end
                if (bus1.load) begin
                    m1_sh = 32'(bus1.digits);
                    m1_dp = 8'(bus1.dp_in);
                end
            end
            e.idx = m1_idx;
            q1.push_back(e);
        end
    end

    // Reference model of the 1-digit counter display.
    initial begin
        exp_t e;
        m2_sh = '0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                e.an = 8'hFF; e.seg = 7'h7F; e.dp = 1'b1;
                m2_sh = '0;
            end else begin
                e = model_out(m2_sh, 8'd0, 0, bus2.blank);
                if (bus2.load) m2_sh = 32'(bus2.digits);
            end
            e.idx = 0;
            q2.push_back(e);
        end
    end

    // Scoreboard: compare each DUT output word against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("sb_an",  32'(bus1.an),        32'(e.an[3:0]));
                check("sb_seg", 32'(bus1.seg),       32'(e.seg));
                check("sb_dp",  32'(bus1.dp),        32'(e.dp));
                check("sb_idx", 32'(bus1.digit_idx), 32'(e.idx));
            end
            if (q2.size() > 0) begin
                e = q2.pop_front();
                check("cnt_an",  32'(bus2.an),        32'(e.an[0:0]));
                check("cnt_seg", 32'(bus2.seg),       32'(e.seg));
                check("cnt_dp",  32'(bus2.dp),        32'(e.dp));
                check("cnt_idx", 32'(bus2.digit_idx), 32'(e.idx));
            end
        end
    end

    // Decade counter driving the single-digit display, loaded every cycle.
    initial begin
        int cnt;
        cnt         = 0;
        bus2.load   = 1'b1;
        bus2.digits = '0;
        bus2.dp_in  = '0;
        bus2.blank  = 1'b0;
        forever begin
            @(negedge clk);
            bus2.digits = 4'(cnt);
            cnt = (cnt == 9) ? 0 : cnt + 1;
        end
    end

    task automatic wait_an(input string tag, input logic [3:0] want);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus1.an == want) break;
        end
        check(tag, 32'(bus1.an), 32'(want));
    endtask

    task automatic load_val(input logic [15:0] d, input logic [3:0] p);
        @(negedge clk);
        bus1.digits = d;
        bus1.dp_in  = p;
        bus1.load   = 1'b1;
        @(negedge clk);
        bus1.load   = 1'b0;
    endtask

    task automatic count_an(input string tag, input logic [3:0] want, input int exp_n);
        int n;
        n = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (bus1.an == want) n++;
        end
        check(tag, 32'(n), 32'(exp_n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    // Directed sequence followed by a random phase.
    initial begin
        bit found;
        n_checks    = 0;
        n_pass      = 0;
        rst         = 1'b0;
        bus1.load   = 1'b0;
        bus1.digits = '0;
        bus1.dp_in  = '0;
        bus1.blank  = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_an",  32'(bus1.an),  32'h0F);
        check("rst_seg", 32'(bus1.seg), 32'h7F);
        check("rst_dp",  32'(bus1.dp),  32'h1);
        rst = 1'b1;

        @(negedge clk);
        check("first_an",  32'(bus1.an),  32'hE);
        check("first_seg", 32'(bus1.seg), 32'h40);
        repeat (2) @(negedge clk);
        check("idx_hold", 32'(bus1.digit_idx), 32'd0);
        @(negedge clk);
        check("idx_step", 32'(bus1.digit_idx), 32'd1);

        load_val(16'h1905, 4'b0000);
        wait_an("s0_an", 4'hE); check("s0_seg", 32'(bus1.seg), 32'h12);
        wait_an("s1_an", 4'hD); check("s1_seg", 32'(bus1.seg), 32'h40);
        wait_an("s2_an", 4'hB); check("s2_seg", 32'(bus1.seg), 32'h10);
        wait_an("s3_an", 4'h7); check("s3_seg", 32'(bus1.seg), 32'h79);

        load_val(16'h0007, 4'b0000);
        wait_an("lz_an0", 4'hE); check("lz_seg0", 32'(bus1.seg), 32'h78);
        count_an("lz_slot0_cnt", 4'hE, 4);
        count_an("lz_dark_cnt",  4'hF, 12);

        load_val(16'h0007, 4'b0100);
        wait_an("dp_an2", 4'hB);
        check("dp_seg2", 32'(bus1.seg), 32'h40);
        check("dp_dp2",  32'(bus1.dp),  32'h0);
        wait_an("dp_an1", 4'hD);
        check("dp_seg1", 32'(bus1.seg), 32'h40);
        check("dp_dp1",  32'(bus1.dp),  32'h1);
        count_an("dp_idx3_dark", 4'h7, 0);

        load_val(16'h000C, 4'b0000);
        wait_an("dash_an", 4'hE); check("dash_seg", 32'(bus1.seg), 32'h3F);
        bus1.blank = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("blank_an", 32'(bus1.an), 32'hF);
        end
        bus1.blank = 1'b0;

        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (m1_idx == 2 && m1_cnt == 3) begin
                found = 1'b1;
                break;
            end
        end
        check("mid_scan_reached", 32'(found), 32'h1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_idx", 32'(bus1.digit_idx), 32'd0);
        check("midrst_an",  32'(bus1.an),  32'hF);
        check("midrst_seg", 32'(bus1.seg), 32'h7F);
        rst = 1'b1;
        @(negedge clk);
        check("post_an",  32'(bus1.an),  32'hE);
        check("post_seg", 32'(bus1.seg), 32'h40);
        check("post_dp",  32'(bus1.dp),  32'h1);

        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            bus1.load   = ($urandom_range(0, 3) == 0);
            bus1.digits = 16'($urandom);
            if ($urandom_range(0, 1) == 0) bus1.digits = bus1.digits & 16'h00FF;
            bus1.dp_in  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            bus1.blank  = ($urandom_range(0, 7) == 0);
        end
        bus1.load  = 1'b0;
        bus1.blank = 1'b0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
